// File: rtl/mux_sel_seq.sv
// Select sequencer for a hard 2:1 mux: resynchronises the select request and
// blanks the muxed path for a guard period before and after each select change.
module mux_sel_seq #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic        RESET_SEL    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sel_req,
  input  logic i_test_mode,
  input  logic i_test_sel,
  output logic o_sel,
  output logic o_en,
  output logic o_busy,
  output logic o_done
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("mux_sel_seq: SYNC_STAGES must be in 2..4");
  end
  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard_cycles
    $error("mux_sel_seq: GUARD_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRE    = 2'd1,
    ST_SWITCH = 2'd2,
    ST_POST   = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LOAD = 8'(GUARD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  state_e     state_q;
  logic       sel_q;
  logic [7:0] cnt_q;
  logic       en_q;
  logic       done_q;
  logic       busy_q;

  // Synchroniser flops reset to RESET_SEL so no sequence fires out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_SEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sel_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Once PRE is entered the sequence is committed; req_s is sampled only in IDLE.
  // busy_q is kept as its own flop so o_busy is not a decode of the state bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= RESET_SEL;
      cnt_q   <= 8'd0;
      en_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (i_test_mode) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_s != sel_q) begin
            state_q <= ST_PRE;
            cnt_q   <= CNT_LOAD;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_PRE: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_SWITCH;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_SWITCH: begin
          sel_q   <= ~sel_q;
          cnt_q   <= CNT_LOAD;
          state_q <= ST_POST;
        end
        ST_POST: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Test mode bypasses the sequencer combinationally; normal mode is pure flops.
  assign o_sel  = i_test_mode ? i_test_sel : sel_q;
  assign o_en   = i_test_mode | en_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
